// File: rtl/jrc_decoder.sv
// Johnson ring-counter decoder.
// A 10-bit Johnson code is captured in stage 1 and decoded into one of 20
// phases in stage 2. Legal phase changes accumulate forward steps and 19->0
// crossings. Illegal codes are counted, and they drop the phase reference.
module jrc_decoder (
  input  logic        C,
  input  logic        R,
  input  logic        CE,
  input  logic [9:0]  D,
  input  logic        CLR,
  output logic [4:0]  PHASE,
  output logic        VALID,
  output logic        ERR,
  output logic [15:0] STEPS,
  output logic [7:0]  WRAPS,
  output logic [7:0]  ERRCNT,
  output logic        SAT
);

  localparam int NUM_PHASES = 20;

  typedef enum logic {S_INIT = 1'b0, S_TRACK = 1'b1} state_t;

  // Legal code for phase k. Phases 0..10 fill ones from the LSB upward.
  // Phases 11..19 then clear ones from the LSB upward.
  function automatic logic [9:0] legal_code(input int k);
    logic [10:0] ones;
    if (k <= 10) begin
      ones = 11'((1 << k) - 1);
      return ones[9:0];
    end
    ones = 11'((1 << (k - 10)) - 1);
    return 10'h3FF & ~ones[9:0];
  endfunction

  // Stage-1 capture
  logic [9:0]  code_q, code_d;
  logic        pend_q, pend_d;

  // Stage-2 outputs and accumulators
  logic [4:0]  phase_q, phase_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [15:0] steps_q, steps_d;
  logic [7:0]  wraps_q, wraps_d;
  logic [7:0]  errcnt_q, errcnt_d;
  logic        sat_q, sat_d;

  // Reference-tracking FSM
  state_t      state_q, state_d;
  logic        tracking;

  // Decode and delta helpers
  logic        dec_legal;
  logic [4:0]  dec_phase;
  logic [4:0]  delta;
  logic        wrap;
  logic [16:0] steps_sum;

  // Stage 1: a CE edge loads the code and marks it pending for decode
  always_comb begin
    pend_d = CE;
    code_d = CE ? D : code_q;
  end

  // Match the captured code against the 20 legal Johnson codes
  always_comb begin
    dec_legal = 1'b0;
    dec_phase = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      if (code_q == legal_code(k)) begin
        dec_legal = 1'b1;
        dec_phase = 5'(k);
      end
    end
  end

  // Forward distance mod 20 from the current reference to the new phase.
  // A wrap means the walk passed through 19->0.
  always_comb begin
    if (dec_phase >= phase_q) delta = dec_phase - phase_q;
    else                      delta = dec_phase + 5'd20 - phase_q;
    wrap      = ({1'b0, phase_q} + {1'b0, delta}) >= 6'd20;
    steps_sum = {1'b0, steps_q} + 17'(delta);
  end

  // FSM next state: CLR always drops the reference.
  // Otherwise, a decoded sample decides between TRACK (legal) and INIT (illegal).
  always_comb begin
    state_d = state_q;
    if (CLR)         state_d = S_INIT;
    else if (pend_q) state_d = dec_legal ? S_TRACK : S_INIT;
  end

  // FSM output: only a held reference lets samples accumulate steps
  always_comb begin
    tracking = (state_q == S_TRACK);
  end

  // Stage 2: decode the pending sample, then apply CLR on top.
  // A sample decoded under CLR behaves as an INIT sample. It still updates PHASE,
  // VALID and ERR, but adds nothing to the counters.
  always_comb begin
    phase_d  = phase_q;
    valid_d  = pend_q;
    err_d    = 1'b0;
    steps_d  = steps_q;
    wraps_d  = wraps_q;
    errcnt_d = errcnt_q;
    sat_d    = sat_q;
    if (pend_q) begin
      if (dec_legal) begin
        phase_d = dec_phase;
        if (tracking && !CLR) begin
          if (steps_sum[16]) begin
            steps_d = 16'hFFFF;
            sat_d   = 1'b1;
          end else begin
            steps_d = steps_sum[15:0];
          end
          if (wrap) wraps_d = wraps_q + 8'd1;
        end
      end else begin
        err_d = 1'b1;
        if (!CLR && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
      end
    end
    if (CLR) begin
      steps_d  = '0;
      wraps_d  = '0;
      errcnt_d = '0;
      sat_d    = 1'b0;
    end
  end

  // State register. Reset wins over CE and CLR and discards any in-flight sample.
  always_ff @(posedge C) begin
    if (R) begin
      code_q   <= '0;
      pend_q   <= 1'b0;
      phase_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      steps_q  <= '0;
      wraps_q  <= '0;
      errcnt_q <= '0;
      sat_q    <= 1'b0;
      state_q  <= S_INIT;
    end else begin
      code_q   <= code_d;
      pend_q   <= pend_d;
      phase_q  <= phase_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      steps_q  <= steps_d;
      wraps_q  <= wraps_d;
      errcnt_q <= errcnt_d;
      sat_q    <= sat_d;
      state_q  <= state_d;
    end
  end

  assign PHASE  = phase_q;
  assign VALID  = valid_q;
  assign ERR    = err_q;
  assign STEPS  = steps_q;
  assign WRAPS  = wraps_q;
  assign ERRCNT = errcnt_q;
  assign SAT    = sat_q;

endmodule
